// File: rtl/duck_hunt_pkg.sv
// ----------------------------------------------------------------------------
// duck_hunt_pkg
//   Items shared across the duck hunt video path.
//     SCREEN_W / SCREEN_H : visible frame buffer size in pixels (160 x 120)
//     COL_BLACK/COL_WHITE : 3-bit colour constants used by the draw logic
//     pixel_t             : packed {x, y, colour} pixel request
//     on_screen()         : true when a coordinate lies inside the frame
// ----------------------------------------------------------------------------
package duck_hunt_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] COL_BLACK = 3'b000;
    localparam logic [2:0] COL_WHITE = 3'b111;

    localparam int PIX_X_W = 8;
    localparam int PIX_Y_W = 7;
    localparam int PIX_C_W = 3;

    typedef struct packed {
        logic [PIX_X_W-1:0] x;
        logic [PIX_Y_W-1:0] y;
        logic [PIX_C_W-1:0] colour;
    } pixel_t;

    // Coordinates arrive zero-extended, so the wrapped "x - 5" and the idle
    // all-ones x both show up here as large values and fail the test.
    function automatic logic on_screen(input int px, input int py);
        return (px < SCREEN_W) && (py < SCREEN_H);
    endfunction

endpackage

// File: rtl/pixel_ram.sv
// ----------------------------------------------------------------------------
// pixel_ram
//   DEPTH-entry simple dual-port storage for queued pixel requests.
//   Parameters:
//     DEPTH : number of entries (power of two)
//     T     : entry type, pixel_t by default
//   Ports:
//     clock : write clock
//     we    : write enable
//     waddr : write address (queue write pointer)
//     wdata : entry written on the rising edge when we is high
//     raddr : read address (queue read pointer)
//     rdata : entry at raddr, available combinationally
// ----------------------------------------------------------------------------
module pixel_ram
    import duck_hunt_pkg::*;
#(
    parameter int  DEPTH = 16,
    parameter type T     = pixel_t,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  T              wdata,
    input  logic [AW-1:0] raddr,
    output T              rdata
);

    T mem [DEPTH];

    // Contents are never reset: only entries between the pointers are ever
    // read, and the pointers themselves are reset in the queue.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The head is read asynchronously so a pop can register it on the same
    // edge, keeping accept-to-plot latency at two edges.
    assign rdata = mem[raddr];

endmodule

// File: rtl/pixel_queue.sv
// ----------------------------------------------------------------------------
// pixel_queue
//   Buffers bursty pixel writes from the draw controllers and replays them to
//   the vga_adapter write port at up to one pixel per enabled cycle.
//
//   Optional feature macro: PIXEL_QUEUE_CLIP_EN
//     defined   : off-screen requests are handshaken but discarded and
//                 counted in 'dropped' (saturating at 255)
//     undefined : every accepted request is stored, 'dropped' is 0
//
//   Ports:
//     clock      : system clock
//     resetn     : asynchronous active-low reset
//     flush      : synchronous clear of all queued entries
//     in_valid   : request present       in_ready : queue can accept
//     in_x/in_y/in_colour : request fields
//     out_enable : adapter may take a pixel this cycle
//     plot/x/y/colour     : registered adapter write port
//     level      : current occupancy (0..DEPTH)
//     dropped    : saturating count of clipped requests
// ----------------------------------------------------------------------------
module pixel_queue
    import duck_hunt_pkg::*;
#(
    parameter int  DEPTH = 16,
    parameter int  X_W   = 8,
    parameter int  Y_W   = 7,
    parameter int  C_W   = 3,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [X_W-1:0] in_x,
    input  logic [Y_W-1:0] in_y,
    input  logic [C_W-1:0] in_colour,
    input  logic           out_enable,
    output logic           plot,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [C_W-1:0] colour,
    output logic [LW-1:0]  level,
    output logic [7:0]     dropped
);

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [C_W-1:0] colour;
    } entry_t;

    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    entry_t        wr_entry;
    entry_t        head;
    logic          accept;
    logic          clipped;
    logic          push;
    logic          pop;

    // Ready depends only on registered occupancy, so a full queue refuses a
    // request even when it is popping on the same edge.
    assign in_ready = (level != FULL_LEVEL) && !flush;
    assign accept   = in_valid && in_ready;
    assign push     = accept && !clipped;

    // An empty queue never pops, so a fresh entry always waits one edge.
    assign pop      = (level != '0) && out_enable && !flush;

    assign wr_entry = '{x: in_x, y: in_y, colour: in_colour};

`ifdef PIXEL_QUEUE_CLIP_EN
    assign clipped = !on_screen(int'(in_x), int'(in_y));

    // Counts requests that were handshaken but discarded; holds at 255.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dropped <= '0;
        end else if (accept && clipped && (dropped != 8'hFF)) begin
            dropped <= dropped + 8'd1;
        end
    end
`else
    assign clipped = 1'b0;
    assign dropped = '0;
`endif

    pixel_ram #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_ram (
        .clock (clock),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Pointers wrap naturally at DEPTH; level is tracked separately so full
    // and empty are unambiguous. Flush wins over any push or pop.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

    // Adapter port: plot is a one-cycle strobe per popped entry, while the
    // coordinates and colour keep their last values between pops.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            plot   <= 1'b0;
            x      <= '0;
            y      <= '0;
            colour <= '0;
        end else begin
            plot <= pop;
            if (pop) begin
                x      <= head.x;
                y      <= head.y;
                colour <= head.colour;
            end
        end
    end

endmodule

// File: tb/tb_pixel_queue.sv
// ----------------------------------------------------------------------------
// tb_pixel_queue
//   Self-checking bench for pixel_queue (default parameters). A queue-based
//   reference model tracks the expected adapter outputs; directed sequences
//   add literal expectations. Honours PIXEL_QUEUE_CLIP_EN like the design.
// ----------------------------------------------------------------------------
module tb_pixel_queue;

    localparam int DEPTH = 16;
    localparam int SCR_W = 160;
    localparam int SCR_H = 120;

    logic       clock      = 1'b0;
    logic       resetn     = 1'b0;
    logic       flush      = 1'b0;
    logic       in_valid   = 1'b0;
    logic [7:0] in_x       = '0;
    logic [6:0] in_y       = '0;
    logic [2:0] in_colour  = '0;
    logic       out_enable = 1'b0;

    logic       in_ready;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic [4:0] level;
    logic [7:0] dropped;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    pixel_queue #(
        .DEPTH (DEPTH),
        .X_W   (8),
        .Y_W   (7),
        .C_W   (3)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_colour  (in_colour),
        .out_enable (out_enable),
        .plot       (plot),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .level      (level),
        .dropped    (dropped)
    );

    // Reference model: a plain queue of pixels updated on each clock edge
    // from the inputs present before that edge.
    typedef struct {
        int px;
        int py;
        int pc;
    } pix_s;

    pix_s mq[$];
    int   m_plot    = 0;
    int   m_x       = 0;
    int   m_y       = 0;
    int   m_c       = 0;
    int   m_dropped = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s at %0t: got %0d required %0d", name, $time, got, exp);
        end
    endtask

    initial begin
        pix_s h;
        bit   ready;
        bit   clip;
        forever begin
            @(posedge clock or negedge resetn);
            if (!resetn) begin
                mq.delete();
                m_plot = 0; m_x = 0; m_y = 0; m_c = 0; m_dropped = 0;
            end else begin
                ready = (mq.size() < DEPTH) && !flush;
                if (mq.size() > 0 && out_enable && !flush) begin
                    h      = mq.pop_front();
                    m_plot = 1;
                    m_x    = h.px;
                    m_y    = h.py;
                    m_c    = h.pc;
                end else begin
                    m_plot = 0;
                end
                if (flush) begin
                    mq.delete();
                end
`ifdef PIXEL_QUEUE_CLIP_EN
                clip = (int'(in_x) >= SCR_W) || (int'(in_y) >= SCR_H);
`else
                clip = 1'b0;
`endif
                if (in_valid && ready) begin
                    if (clip) begin
                        if (m_dropped < 255) m_dropped++;
                    end else begin
                        h.px = int'(in_x);
                        h.py = int'(in_y);
                        h.pc = int'(in_colour);
                        mq.push_back(h);
                    end
                end
            end
        end
    end

    // Model comparison on every falling edge while out of reset.
    initial begin
        forever begin
            @(negedge clock);
            if (resetn) begin
                check("m_plot",     32'(plot),     32'(m_plot));
                check("m_x",        32'(x),        32'(m_x));
                check("m_y",        32'(y),        32'(m_y));
                check("m_colour",   32'(colour),   32'(m_c));
                check("m_level",    32'(level),    32'(mq.size()));
                check("m_in_ready", 32'(in_ready), 32'((mq.size() < DEPTH) && !flush));
                check("m_dropped",  32'(dropped),  32'(m_dropped));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_stimulus(input int px, input int py, input int pc);
        in_valid  = 1'b1;
        in_x      = 8'(px);
        in_y      = 7'(py);
        in_colour = 3'(pc);
    endtask

    initial begin
        int plots;
        int lx, ly, lc;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_plot",     32'(plot),     32'd0);
        check("rst_x",        32'(x),        32'd0);
        check("rst_level",    32'(level),    32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_dropped",  32'(dropped),  32'd0);
        resetn = 1'b1;
        step();

        // Single pixel, two-edge latency
        out_enable = 1'b1;
        apply_stimulus(10, 20, 7);
        step();
        in_valid = 1'b0;
        check("lat_plot_k", 32'(plot), 32'd0);
        step();
        check("lat_plot",   32'(plot),   32'd1);
        check("lat_x",      32'(x),      32'd10);
        check("lat_y",      32'(y),      32'd20);
        check("lat_colour", 32'(colour), 32'd7);
        step();
        check("lat_plot_end", 32'(plot), 32'd0);
        check("lat_x_hold",   32'(x),    32'd10);

        // Fill to full, refuse a 17th, then drain in order
        out_enable = 1'b0;
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(i, i, i % 8);
            step();
        end
        check("full_level",    32'(level),    32'd16);
        check("full_in_ready", 32'(in_ready), 32'd0);
        apply_stimulus(99, 1, 1);
        step();
        check("full_17th_level", 32'(level), 32'd16);
        in_valid   = 1'b0;
        out_enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            check("drain_plot", 32'(plot), 32'd1);
            check("drain_x",    32'(x),    32'(i));
        end
        step();
        check("drain_done_plot",  32'(plot),  32'd0);
        check("drain_done_level", 32'(level), 32'd0);

        // Simultaneous push and pop at level 8
        out_enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(100 + i, i, i % 8);
            step();
        end
        check("pp_level_start", 32'(level), 32'd8);
        out_enable = 1'b1;
        for (int j = 0; j < 20; j++) begin
            apply_stimulus(108 + j, 8 + j, j % 8);
            step();
            check("pp_level", 32'(level), 32'd8);
            check("pp_x",     32'(x),     32'(100 + j));
        end
        in_valid = 1'b0;
        repeat (9) step();
        check("pp_drained", 32'(level), 32'd0);

        // Flush at level 5 together with a request
        out_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(50 + i, i, 3);
            step();
        end
        check("fl_level_before", 32'(level), 32'd5);
        apply_stimulus(77, 7, 7);
        flush = 1'b1;
        #1;
        check("fl_in_ready", 32'(in_ready), 32'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_level", 32'(level), 32'd0);
        check("fl_plot",  32'(plot),  32'd0);
        out_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("fl_no_plot", 32'(plot), 32'd0);
        end

        // Off-screen requests
        plots = 0; lx = 0; ly = 0; lc = 0;
        for (int i = 0; i < 9; i++) begin
            if (i == 0)      apply_stimulus(255, 127, 0);
            else if (i == 1) apply_stimulus(160, 5, 7);
            else if (i == 2) apply_stimulus(159, 119, 7);
            else             in_valid = 1'b0;
            step();
            if (plot === 1'b1) begin
                plots++;
                lx = int'(x); ly = int'(y); lc = int'(colour);
            end
        end
        check("clip_last_x",      32'(lx), 32'd159);
        check("clip_last_y",      32'(ly), 32'd119);
        check("clip_last_colour", 32'(lc), 32'd7);
`ifdef PIXEL_QUEUE_CLIP_EN
        check("clip_plots",   32'(plots),   32'd1);
        check("clip_dropped", 32'(dropped), 32'd2);
        apply_stimulus(200, 10, 1);
        repeat (260) step();
        in_valid = 1'b0;
        check("clip_saturate", 32'(dropped), 32'd255);
        check("clip_sat_lvl",  32'(level),   32'd0);
`else
        check("clip_plots",   32'(plots),   32'd3);
        check("clip_dropped", 32'(dropped), 32'd0);
`endif

        // Asynchronous reset mid-drain at level 6
        out_enable = 1'b0;
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(30 + i, i + 1, 5);
            step();
        end
        in_valid   = 1'b0;
        out_enable = 1'b1;
        step();
        check("ar_level_before", 32'(level), 32'd6);
        check("ar_plot_before",  32'(plot),  32'd1);
        check("ar_x_before",     32'(x),     32'd30);
        #2;
        resetn = 1'b0;
        #1;
        check("ar_plot",     32'(plot),     32'd0);
        check("ar_x",        32'(x),        32'd0);
        check("ar_y",        32'(y),        32'd0);
        check("ar_colour",   32'(colour),   32'd0);
        check("ar_level",    32'(level),    32'd0);
        check("ar_in_ready", 32'(in_ready), 32'd1);
        check("ar_dropped",  32'(dropped),  32'd0);
        step();
        resetn = 1'b1;
        step();
        check("ar_rel_level", 32'(level),    32'd0);
        check("ar_rel_ready", 32'(in_ready), 32'd1);
        check("ar_rel_plot",  32'(plot),     32'd0);
        apply_stimulus(5, 6, 2);
        step();
        in_valid = 1'b0;
        step();
        check("ar_post_plot", 32'(plot), 32'd1);
        check("ar_post_x",    32'(x),    32'd5);
        check("ar_post_y",    32'(y),    32'd6);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/pixel_queue.md
# pixel_queue

Buffers pixel write requests from the bird/hunter draw controller and replays them to the `vga_adapter` write port at one pixel per enabled cycle. It decouples the draw FSMs, which emit pixels in bursts, from the frame buffer write port. It optionally drops off-screen pixels, such as the idle `x_out = -1` value or wrapped `x - 5` coordinates, before they reach the adapter. It sits between `draw_control`/`draw_bird` and `vga_adapter`.

## Interface
- `DEPTH`, 16 — entries in the queue; must be a power of two, minimum 4.
- `X_W`, 8 — x coordinate width.
- `Y_W`, 7 — y coordinate width.
- `C_W`, 3 — colour width.
- `clock`  in  1  — system clock (CLOCK_50 domain); the only clock.
- `resetn`  in  1  — asynchronous, active-low reset.
- `flush`  in  1  — synchronous queue clear.
- `in_valid`  in  1  — a pixel request is present.
- `in_ready`  out  1  — the queue can accept a pixel.
- `in_x`  in  X_W  — request x.
- `in_y`  in  Y_W  — request y.
- `in_colour`  in  C_W  — request colour.
- `out_enable`  in  1  — the adapter may take a pixel this cycle.
- `plot`  out  1  — to `vga_adapter.plot`; registered.
- `x`  out  X_W  — to `vga_adapter.x`; registered.
- `y`  out  Y_W  — to `vga_adapter.y`; registered.
- `colour`  out  C_W  — to `vga_adapter.colour`; registered.
- `level`  out  $clog2(DEPTH)+1  — current occupancy.
- `dropped`  out  8  — saturating count of clipped pixels.

## Operation
- Storage is a circular buffer with read and write pointers of width $clog2(DEPTH) that wrap naturally. `level` is a separate counter.
- `in_ready = (level != DEPTH) && !flush`. This is combinational from registered state and does not depend on a same-cycle pop.
- Push happens when `in_valid && in_ready` (after the clip check, if enabled).
- Pop happens when `level != 0 && out_enable && !flush`. A pop loads `x`/`y`/`colour` from the head and sets `plot=1` for the next cycle.
- With no pop, `plot` goes to 0 next cycle. `x`/`y`/`colour` hold their last values.
- Push and pop in the same cycle leave `level` unchanged. This is legal at any nonzero level below DEPTH.
- When full, `in_ready=0`, so no push occurs even if a pop happens that cycle.
- When empty, a push and a pop cannot coincide. The pushed entry pops on the following enabled cycle.
- `flush` resets both pointers and `level` to 0 and forces `plot` to 0 next cycle. It has priority over push and pop. `dropped` is unaffected.
- Reset values: all pointers, `level`, `plot`, `x`, `y`, `colour`, and `dropped` are 0, and `in_ready` is 1. Reset takes effect immediately on assertion, including mid-burst; queued entries are discarded.

## Timing
- The minimum latency from accept to plot is 2 edges: a request accepted at edge k is written at k, popped at k+1, and shows `plot=1` with its data during the cycle after k+1.
- Sustained throughput is 1 pixel/cycle when `out_enable` is held high.
- Ordering is strictly FIFO. There is no reordering and no duplication.
- `level` updates on the same edge as the push or pop.
- `dropped` increments on the edge of the rejected request and saturates at 255.

## Configuration
- `PIXEL_QUEUE_CLIP_EN` defined:
  - A request with `in_x >= SCREEN_W` or `in_y >= SCREEN_H` is handshaken (it sees `in_ready`) but not stored.
  - The clipped request increments `dropped`.
- `PIXEL_QUEUE_CLIP_EN` undefined:
  - Every accepted request is stored.
  - `dropped` is tied to 0.

## Structure
- Shared package `duck_hunt_pkg` holds:
  - `SCREEN_W=160` and `SCREEN_H=120`.
  - Colour constants `COL_BLACK=3'b000` and `COL_WHITE=3'b111`.
  - The packed pixel typedef `{x, y, colour}` as `pixel_t`.
- One sub-module, `pixel_ram`: a DEPTH×`pixel_t` simple dual-port array with a synchronous write port and a read port addressed by the read pointer.
- Pointer, level, and output-register logic stays in `pixel_queue`.

## Test plan
- Reset, then push (10,20,7) with `out_enable=1`: `plot=1`, x=10, y=20, colour=7, exactly 2 edges after acceptance; `plot=0` the following cycle.
- Hold `out_enable=0` and push 16 pixels (x=0..15): `level=16` and `in_ready=0`; a 17th request is not accepted. Then raise `out_enable`: x=0..15 appear on 16 consecutive cycles in order.
- At `level=8`, drive push and pop every cycle for 20 cycles: `level` stays 8 and output order matches input order.
- At `level=5`, assert `flush` for 1 cycle together with `in_valid`: `level=0` and `plot=0` next cycle; the flush-cycle pixel never plots.
- With `PIXEL_QUEUE_CLIP_EN`, push (255,127,0), (160,5,7), and (159,119,7): only (159,119,7) plots and `dropped=2`.
- Assert `resetn=0` asynchronously mid-drain at `level=6`: outputs go to 0 without waiting for an edge; after release, `level=0` and `in_ready=1`.
